// File: rtl/mon_exp_ladder.sv
// Montgomery-domain modular exponentiation engine.
// The engine computes m_bar^e in the Montgomery domain using one bit-serial radix-2 Montgomery
// multiplier. Two modes are supported: left-to-right square-and-multiply, and a
// constant-time Montgomery ladder that always performs two multiplies per exponent bit.
module mon_exp_ladder #(
    parameter int unsigned BITS  = 512,
    parameter int unsigned EBITS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [BITS-1:0]  x_bar,
    input  logic [BITS-1:0]  m_bar,
    input  logic [BITS-1:0]  e,
    input  logic [EBITS-1:0] e_idx,
    input  logic [BITS-1:0]  n,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [BITS-1:0]  ans
);

    // The accumulator needs two guard bits so that T + b + n never overflows.
    localparam int unsigned TW = BITS + 2;
    localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StMul,
        StSub,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Latched operation context
    logic             mode_q, mode_d;
    logic [BITS-1:0]  n_q, n_d;
    logic             err_q, err_d;
    logic [BITS-1:0]  ans_q, ans_d;

    // R0 is A in mode 0. R1 holds m_bar in mode 0 and is never written there.
    logic [BITS-1:0]  r0_q, r0_d;
    logic [BITS-1:0]  r1_q, r1_d;

    // The exponent is left-aligned at acceptance, so the current bit is always the MSB.
    logic [BITS-1:0]  e_sh_q, e_sh_d;
    logic [EBITS-1:0] idx_q, idx_d;
    logic             ph_q, ph_d;

    // Multiplier state
    logic [BITS-1:0]  a_q, a_d;
    logic [BITS-1:0]  b_q, b_d;
    logic [TW-1:0]    t_q, t_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dst_q, dst_d;

    // Shared decode terms
    logic             cur_bit;
    logic             more_ph;
    logic             last_op;
    logic             mul_last;
    logic             err_now;

    assign cur_bit  = e_sh_q[BITS-1];
    // A second multiply follows for this bit: always in the ladder, and only for set bits
    // in square-and-multiply.
    assign more_ph  = ~ph_q & (mode_q | cur_bit);
    assign last_op  = ~more_ph & (idx_q == '0);
    assign mul_last = (cnt_q == CW'(BITS - 1));
    assign err_now  = ~n[0] | (32'(e_idx) > 32'(BITS - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSel;
                end
            end
            // A rejected request still passes through SEL once so that done lands one
            // cycle after acceptance.
            StSel: begin
                state_d = err_q ? StDone : StMul;
            end
            StMul: begin
                if (mul_last) begin
                    state_d = StSub;
                end
            end
            StSub: begin
                state_d = last_op ? StDone : StSel;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state_q == StSel) || (state_q == StMul) || (state_q == StSub);
        done = (state_q == StDone);
        err  = err_q;
        ans  = ans_q;
    end

    // Datapath next-state logic
    always_comb begin
        logic [TW-1:0]   t_add;
        logic [TW-1:0]   t_odd;
        logic [BITS-1:0] res;
        logic [31:0]     shamt;

        mode_d = mode_q;
        n_d    = n_q;
        err_d  = err_q;
        ans_d  = ans_q;
        r0_d   = r0_q;
        r1_d   = r1_q;
        e_sh_d = e_sh_q;
        idx_d  = idx_q;
        ph_d   = ph_q;
        a_d    = a_q;
        b_d    = b_q;
        t_d    = t_q;
        cnt_d  = cnt_q;
        dst_d  = dst_q;
        shamt  = '0;

        // One radix-2 step: add b if the current bit of a is set, make T even, halve.
        t_add = t_q + (a_q[0] ? {2'b00, b_q} : '0);
        t_odd = t_add + (t_add[0] ? {2'b00, n_q} : '0);
        // Final conditional subtract; the result is below n, so the low BITS bits suffice.
        res   = (t_q >= {2'b00, n_q}) ? (t_q[BITS-1:0] - n_q) : t_q[BITS-1:0];

        case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d = mode;
                    n_d    = n;
                    r0_d   = x_bar;
                    r1_d   = m_bar;
                    shamt  = 32'(BITS - 1) - 32'(e_idx);
                    e_sh_d = e << shamt;
                    idx_d  = e_idx;
                    ph_d   = 1'b0;
                    err_d  = err_now;
                    ans_d  = '0;
                end
            end
            StSel: begin
                t_d   = '0;
                cnt_d = '0;
                if (!mode_q) begin
                    // Square, then multiply by m_bar; both land in A.
                    a_d   = r0_q;
                    b_d   = ph_q ? r1_q : r0_q;
                    dst_d = 1'b0;
                end else if (!ph_q) begin
                    // Cross product: R0 for a set bit, R1 for a clear bit.
                    a_d   = r0_q;
                    b_d   = r1_q;
                    dst_d = ~cur_bit;
                end else begin
                    // Square the register that did not take the cross product.
                    a_d   = cur_bit ? r1_q : r0_q;
                    b_d   = cur_bit ? r1_q : r0_q;
                    dst_d = cur_bit;
                end
            end
            StMul: begin
                t_d   = t_odd >> 1;
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
            end
            StSub: begin
                if (dst_q) begin
                    r1_d = res;
                end else begin
                    r0_d = res;
                end
                if (more_ph) begin
                    ph_d = 1'b1;
                end else begin
                    ph_d = 1'b0;
                    if (idx_q != '0) begin
                        idx_d  = idx_q - EBITS'(1);
                        e_sh_d = e_sh_q << 1;
                    end
                end
                // The answer is R0 after the final write, whichever register that was.
                if (last_op) begin
                    ans_d = dst_q ? r0_q : res;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= 1'b0;
            n_q    <= '0;
            err_q  <= 1'b0;
            ans_q  <= '0;
            r0_q   <= '0;
            r1_q   <= '0;
            e_sh_q <= '0;
            idx_q  <= '0;
            ph_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            t_q    <= '0;
            cnt_q  <= '0;
            dst_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            n_q    <= n_d;
            err_q  <= err_d;
            ans_q  <= ans_d;
            r0_q   <= r0_d;
            r1_q   <= r1_d;
            e_sh_q <= e_sh_d;
            idx_q  <= idx_d;
            ph_q   <= ph_d;
            a_q    <= a_d;
            b_q    <= b_d;
            t_q    <= t_d;
            cnt_q  <= cnt_d;
            dst_q  <= dst_d;
        end
    end

endmodule

// File: tb/tb_mon_exp_ladder.sv
// Self-checking bench for mon_exp_ladder at BITS=16. A plain-arithmetic model predicts the
// result and latency of each accepted request; a negedge process compares every cycle.
module tb_mon_exp_ladder;

    localparam int unsigned BITS  = 16;
    localparam int unsigned EBITS = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mode;
    logic [BITS-1:0]  x_bar;
    logic [BITS-1:0]  m_bar;
    logic [BITS-1:0]  e;
    logic [EBITS-1:0] e_idx;
    logic [BITS-1:0]  n;
    logic             busy;
    logic             done;
    logic             err;
    logic [BITS-1:0]  ans;

    always #5 clk = ~clk;

    mon_exp_ladder #(
        .BITS  (BITS),
        .EBITS (EBITS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .x_bar (x_bar),
        .m_bar (m_bar),
        .e     (e),
        .e_idx (e_idx),
        .n     (n),
        .busy  (busy),
        .done  (done),
        .err   (err),
        .ans   (ans)
    );

    int errors = 0;
    int checks = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Result = (m^e mod n) * R mod n with m = m_bar / R; assumes x_bar = R mod n.
    function automatic void model(input logic md, input logic [15:0] mb, input logic [15:0] ee,
                                  input logic [9:0] ei, input logic [15:0] nn,
                                  output logic er, output logic [15:0] an, output int lat);
        longint nl, rinv, m, r;
        int pop;
        er = (nn[0] == 1'b0) || (ei > 10'd15);
        if (er) begin
            an  = '0;
            lat = 1;
            return;
        end
        nl   = longint'(nn);
        rinv = 0;
        for (longint k = 1; k < nl; k++) begin
            if (((k << 16) % nl) == 1) begin
                rinv = k;
                break;
            end
        end
        m   = (longint'(mb) * rinv) % nl;
        r   = 1 % nl;
        pop = 0;
        for (int i = int'(ei); i >= 0; i--) begin
            r = (r * r) % nl;
            if (ee[i]) begin
                r = (r * m) % nl;
                pop++;
            end
        end
        an  = 16'((r << 16) % nl);
        lat = (md ? 2 * (int'(ei) + 1) : int'(ei) + 1 + pop) * int'(BITS + 2);
    endfunction

    // Transaction-level model of the request handshake
    typedef enum {MIdle, MRun, MDone} mst_e;
    mst_e        mst = MIdle;
    int          cyc = 0;
    int          m_rel = 0;
    int          m_lat = 0;
    int          m_acc = 0;
    logic        m_err_res;
    logic        m_err = 1'b0;
    logic [15:0] m_res;
    logic [15:0] m_ans = '0;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mst   = MIdle;
            m_ans = '0;
            m_err = 1'b0;
        end else begin
            case (mst)
                MIdle: begin
                    if (start) begin
                        model(mode, m_bar, e, e_idx, n, m_err_res, m_res, m_lat);
                        mst   = MRun;
                        m_rel = 0;
                        m_acc = cyc;
                    end
                end
                MRun: begin
                    m_rel++;
                    if (m_rel == m_lat) begin
                        mst   = MDone;
                        m_ans = m_res;
                        m_err = m_err_res;
                    end
                end
                default: mst = MIdle;
            endcase
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {63'b0, busy}, {63'b0, mst == MRun});
            check("done", {63'b0, done}, {63'b0, mst == MDone});
            if (mst != MRun) begin
                check("ans", {48'b0, ans}, {48'b0, m_ans});
                check("err", {63'b0, err}, {63'b0, m_err});
            end
        end
    end

    task automatic scramble();
        mode  = 1'($urandom);
        x_bar = 16'($urandom);
        m_bar = 16'($urandom);
        e     = 16'($urandom);
        e_idx = 10'($urandom);
        n     = 16'($urandom);
    endtask

    task automatic launch(input logic md, input logic [15:0] xb, input logic [15:0] mb,
                          input logic [15:0] ee, input logic [9:0] ei, input logic [15:0] nn);
        @(negedge clk);
        mode  = md;
        x_bar = xb;
        m_bar = mb;
        e     = ee;
        e_idx = ei;
        n     = nn;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input string name, output logic [15:0] got_ans,
                             output logic got_err, output int lat);
        int k = 0;
        while (done !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({name, " done seen"}, {63'b0, done}, 64'd1);
        got_ans = ans;
        got_err = err;
        lat     = cyc - m_acc;
        @(negedge clk);
    endtask

    task automatic run(input string name, input logic md, input logic [15:0] xb,
                       input logic [15:0] mb, input logic [15:0] ee, input logic [9:0] ei,
                       input logic [15:0] nn, output logic [15:0] got_ans,
                       output logic got_err, output int lat);
        launch(md, xb, mb, ee, ei, nn);
        wait_done(name, got_ans, got_err, lat);
    endtask

    initial begin
        logic [15:0] ga;
        logic        ge;
        int          lat;
        logic [15:0] pa;
        logic        pe;
        int          pl;
        logic [15:0] rn;
        int          k;

        reset = 1'b1;
        start = 1'b0;
        scramble();

        // Pin the model with hand-computed values
        model(1'b0, 16'd26, 16'd300, 10'd8, 16'd589, pe, pa, pl);
        check("model ans", {48'b0, pa}, 64'd529);
        check("model lat", 64'(pl), 64'd234);
        model(1'b1, 16'd26, 16'd0, 10'd0, 16'd589, pe, pa, pl);
        check("model one", {48'b0, pa}, 64'd157);
        check("model lat1", 64'(pl), 64'd36);

        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", {63'b0, busy}, 64'd0);
        check("reset done", {63'b0, done}, 64'd0);
        check("reset err", {63'b0, err}, 64'd0);
        check("reset ans", {48'b0, ans}, 64'd0);
        reset = 1'b0;

        // Directed cases
        run("sqm", 1'b0, 16'd157, 16'd26, 16'd300, 10'd8, 16'd589, ga, ge, lat);
        check("sqm ans", {48'b0, ga}, 64'd529);
        check("sqm err", {63'b0, ge}, 64'd0);
        check("sqm lat", 64'(lat), 64'd234);

        run("ladder", 1'b1, 16'd157, 16'd26, 16'd300, 10'd8, 16'd589, ga, ge, lat);
        check("ladder ans", {48'b0, ga}, 64'd529);
        check("ladder lat", 64'(lat), 64'd324);

        run("ladder511", 1'b1, 16'd157, 16'd26, 16'd511, 10'd8, 16'd589, ga, ge, lat);
        check("ladder511 lat", 64'(lat), 64'd324);

        run("e0 sqm", 1'b0, 16'd157, 16'd26, 16'd0, 10'd0, 16'd589, ga, ge, lat);
        check("e0 sqm ans", {48'b0, ga}, 64'd157);
        check("e0 sqm lat", 64'(lat), 64'd18);

        run("e0 ladder", 1'b1, 16'd157, 16'd26, 16'd0, 10'd0, 16'd589, ga, ge, lat);
        check("e0 ladder ans", {48'b0, ga}, 64'd157);
        check("e0 ladder lat", 64'(lat), 64'd36);

        run("even n", 1'b0, 16'd157, 16'd26, 16'd300, 10'd8, 16'd588, ga, ge, lat);
        check("even n err", {63'b0, ge}, 64'd1);
        check("even n ans", {48'b0, ga}, 64'd0);
        check("even n lat", 64'(lat), 64'd1);

        run("big idx", 1'b1, 16'd157, 16'd26, 16'd300, 10'd16, 16'd589, ga, ge, lat);
        check("big idx err", {63'b0, ge}, 64'd1);
        check("big idx lat", 64'(lat), 64'd1);

        // Reset 100 cycles into a run, with start raised alongside it
        launch(1'b0, 16'd157, 16'd26, 16'd300, 10'd8, 16'd589);
        repeat (99) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("abort busy", {63'b0, busy}, 64'd0);
        repeat (300) @(negedge clk);
        run("restart", 1'b0, 16'd157, 16'd26, 16'd300, 10'd8, 16'd589, ga, ge, lat);
        check("restart ans", {48'b0, ga}, 64'd529);

        // start held high across a run while the inputs churn
        @(negedge clk);
        mode  = 1'b0;
        x_bar = 16'd157;
        m_bar = 16'd26;
        e     = 16'd300;
        e_idx = 10'd8;
        n     = 16'd589;
        start = 1'b1;
        @(negedge clk);
        k = 0;
        while (mst != MDone && k < 2000) begin
            scramble();
            @(negedge clk);
            k++;
        end
        check("held done", {63'b0, done}, 64'd1);
        check("held ans", {48'b0, ans}, 64'd529);
        mode  = 1'b1;
        x_bar = 16'd157;
        m_bar = 16'd26;
        e     = 16'd0;
        e_idx = 10'd0;
        n     = 16'd589;
        repeat (2) @(negedge clk);
        start = 1'b0;
        scramble();
        wait_done("held next", ga, ge, lat);
        check("held next ans", {48'b0, ga}, 64'd157);
        check("held next lat", 64'(lat), 64'd36);

        // Randomized requests, checked by the every-cycle compare
        for (int i = 0; i < 14; i++) begin
            rn = 16'($urandom_range(3, 32767)) | 16'd1;
            if ($urandom_range(0, 7) == 0) begin
                rn = rn & 16'hfffe;
            end
            run("rand", 1'($urandom), 16'(32'd65536 % 32'(rn)), 16'($urandom % 32'(rn)),
                16'($urandom), 10'($urandom_range(0, 17)), rn, ga, ge, lat);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, required completion before 90000 cycles");
        $fatal(1);
    end

endmodule
